// File: rtl/md_unit.sv
// md_unit: multi-cycle mult/div unit with HI/LO registers; define MD_MADD_EN to enable madd (op=110)
module md_unit #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(15) + 1;
  localparam logic [2:0] OP_MULT = 3'b000, OP_MULTU = 3'b001, OP_DIV = 3'b010, OP_DIVU = 3'b011,
                         OP_MTHI = 3'b100, OP_MTLO = 3'b101, OP_MADD = 3'b110;
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [WIDTH-1:0] hi_n, lo_n, pend_hi, pend_lo, pend_hi_n, pend_lo_n;
  logic pend_wr, pend_wr_n;
  logic [2*WIDTH-1:0] prod_s, prod_u;
  logic neg_a, neg_b;
  logic [WIDTH-1:0] mag_a, mag_b, quo, rem, q, r;
`ifdef MD_MADD_EN
  logic pend_acc, pend_acc_n;
  logic [2*WIDTH-1:0] acc_sum;
`endif
  // Full-width products and sign-magnitude division of the issue-edge operands
  always_comb begin
    prod_s = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
    prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    neg_a  = (op == OP_DIV) && a[WIDTH-1];
    neg_b  = (op == OP_DIV) && b[WIDTH-1];
    mag_a  = neg_a ? -a : a;
    mag_b  = (b == '0) ? WIDTH'(1) : (neg_b ? -b : b);
    q      = mag_a / mag_b;
    r      = mag_a % mag_b;
    quo    = (neg_a ^ neg_b) ? -q : q;
    rem    = neg_a ? -r : r;
  end
`ifdef MD_MADD_EN
  // Accumulate onto HI/LO as they stand at completion
  always_comb acc_sum = {hi, lo} + {pend_hi, pend_lo};
`endif
  // Next-state, counter, pending result and HI/LO update
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    hi_n      = hi;
    lo_n      = lo;
    pend_hi_n = pend_hi;
    pend_lo_n = pend_lo;
    pend_wr_n = pend_wr;
`ifdef MD_MADD_EN
    pend_acc_n = pend_acc;
`endif
    if (state == IDLE) begin
      if (start) begin
        if (op == OP_MULT || op == OP_MULTU) begin
          state_n                = RUN;
          cnt_n                  = CW'(MUL_CYCLES);
          {pend_hi_n, pend_lo_n} = op[0] ? prod_u : prod_s;
          pend_wr_n              = 1'b1;
`ifdef MD_MADD_EN
          pend_acc_n             = 1'b0;
`endif
        end else if (op == OP_DIV || op == OP_DIVU) begin
          state_n                = RUN;
          cnt_n                  = CW'(DIV_CYCLES);
          {pend_hi_n, pend_lo_n} = {rem, quo};
          pend_wr_n              = (b != '0);
`ifdef MD_MADD_EN
          pend_acc_n             = 1'b0;
`endif
`ifdef MD_MADD_EN
        end else if (op == OP_MADD) begin
          state_n                = RUN;
          cnt_n                  = CW'(MUL_CYCLES);
          {pend_hi_n, pend_lo_n} = prod_s;
          pend_wr_n              = 1'b1;
          pend_acc_n             = 1'b1;
`endif
        end else if (op == OP_MTHI) begin
          hi_n = a;
        end else if (op == OP_MTLO) begin
          lo_n = a;
        end
      end
    end else if (cnt > CW'(1)) begin
      cnt_n = cnt - CW'(1);
    end else begin
      state_n = IDLE;
`ifdef MD_MADD_EN
      if (pend_wr) {hi_n, lo_n} = pend_acc ? acc_sum : {pend_hi, pend_lo};
`else
      if (pend_wr) {hi_n, lo_n} = {pend_hi, pend_lo};
`endif
    end
    busy = (state == RUN);
  end
  // State and data registers; reset discards any in-flight result
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      hi      <= '0;
      lo      <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_wr <= 1'b0;
`ifdef MD_MADD_EN
      pend_acc <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      hi      <= hi_n;
      lo      <= lo_n;
      pend_hi <= pend_hi_n;
      pend_lo <= pend_lo_n;
      pend_wr <= pend_wr_n;
`ifdef MD_MADD_EN
      pend_acc <= pend_acc_n;
`endif
    end
  end
`ifndef SYNTHESIS
  // Hazard logic should never issue while busy; flag it in simulation
  always @(posedge clk) if (!reset && start && state == RUN) $display("md_unit: warning, start ignored while busy");
`endif
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed self-checking bench for md_unit (default and short/long latency instances)
module tb_md_unit;
  logic clk = 1'b0, reset = 1'b1;
  logic start0 = 1'b0, start1 = 1'b0;
  logic [2:0] op0 = '0, op1 = '0;
  logic [31:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic busy0, busy1;
  logic [31:0] hi0, lo0, hi1, lo1;
  int tests = 0, fails = 0;
  md_unit dut0 (.clk(clk), .reset(reset), .start(start0), .op(op0), .a(a0), .b(b0), .busy(busy0), .hi(hi0), .lo(lo0));
  md_unit #(.WIDTH(32), .MUL_CYCLES(1), .DIV_CYCLES(15)) dut1 (.clk(clk), .reset(reset), .start(start1), .op(op1), .a(a1), .b(b1), .busy(busy1), .hi(hi1), .lo(lo1));
  always #5 clk = ~clk;
  // Issue one op at the next posedge (called at a negedge), then count busy cycles; returns at a negedge
  task automatic do_op(input int d, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, output int n);
    if (d == 0) begin start0 = 1'b1; op0 = o; a0 = x; b0 = y; end
    else begin start1 = 1'b1; op1 = o; a1 = x; b1 = y; end
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
    n = 0;
    while ((d == 0 ? busy0 : busy1) && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask
  task automatic test_reset;
    reset = 1'b1;
    #12;
    tests++; if (busy0 !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busy0); end
    tests++; if ({hi0, lo0} !== 64'h0) begin fails++; $display("FAIL reset_hilo got %h exp 0", {hi0, lo0}); end
    @(negedge clk);
    reset = 1'b0;
  endtask
  task automatic test_mult;
    int n;
    do_op(0, 3'b000, 32'hFFFFFFFF, 32'h2, n);
    tests++; if (n !== 5) begin fails++; $display("FAIL mult_busy got %0d exp 5", n); end
    tests++; if ({hi0, lo0} !== 64'hFFFFFFFF_FFFFFFFE) begin fails++; $display("FAIL mult got %h exp FFFFFFFFFFFFFFFE", {hi0, lo0}); end
    do_op(0, 3'b001, 32'hFFFFFFFF, 32'h2, n);
    tests++; if ({hi0, lo0} !== 64'h00000001_FFFFFFFE) begin fails++; $display("FAIL multu got %h exp 00000001FFFFFFFE", {hi0, lo0}); end
    do_op(0, 3'b000, 32'h7FFFFFFF, 32'h80000000, n);
    tests++; if ({hi0, lo0} !== 64'hC0000000_80000000) begin fails++; $display("FAIL mult_big got %h exp C000000080000000", {hi0, lo0}); end
  endtask
  task automatic test_div;
    int n;
    do_op(0, 3'b010, 32'hFFFFFFF9, 32'h2, n);
    tests++; if (n !== 10) begin fails++; $display("FAIL div_busy got %0d exp 10", n); end
    tests++; if ({hi0, lo0} !== 64'hFFFFFFFF_FFFFFFFD) begin fails++; $display("FAIL div got %h exp FFFFFFFFFFFFFFFD", {hi0, lo0}); end
    do_op(0, 3'b011, 32'h7, 32'h2, n);
    tests++; if ({hi0, lo0} !== 64'h00000001_00000003) begin fails++; $display("FAIL divu got %h exp 0000000100000003", {hi0, lo0}); end
    do_op(0, 3'b010, 32'd7, 32'hFFFFFFFE, n);
    tests++; if ({hi0, lo0} !== 64'h00000001_FFFFFFFD) begin fails++; $display("FAIL div_negb got %h exp 00000001FFFFFFFD", {hi0, lo0}); end
  endtask
  task automatic test_div_boundary;
    int n;
    do_op(0, 3'b100, 32'h11, 32'h0, n);
    do_op(0, 3'b101, 32'h22, 32'h0, n);
    do_op(0, 3'b011, 32'h1234, 32'h0, n);
    tests++; if (n !== 10) begin fails++; $display("FAIL div0_busy got %0d exp 10", n); end
    tests++; if ({hi0, lo0} !== 64'h00000011_00000022) begin fails++; $display("FAIL div0 got %h exp 0000001100000022", {hi0, lo0}); end
    do_op(0, 3'b010, 32'h80000000, 32'hFFFFFFFF, n);
    tests++; if ({hi0, lo0} !== 64'h00000000_80000000) begin fails++; $display("FAIL div_ovf got %h exp 0000000080000000", {hi0, lo0}); end
  endtask
  task automatic test_reserved;
    int n;
    do_op(0, 3'b111, 32'h5, 32'h5, n);
    tests++; if (n !== 0) begin fails++; $display("FAIL op111_busy got %0d exp 0", n); end
    tests++; if ({hi0, lo0} !== 64'h00000000_80000000) begin fails++; $display("FAIL op111 got %h exp 0000000080000000", {hi0, lo0}); end
  endtask
  task automatic test_mthi_mtlo;
    int n0, n1;
    do_op(0, 3'b100, 32'hAAAA0000, 32'h0, n0);
    tests++; if ({hi0, lo0} !== 64'hAAAA0000_80000000) begin fails++; $display("FAIL mthi_only got %h exp AAAA000080000000", {hi0, lo0}); end
    do_op(0, 3'b101, 32'h00005555, 32'h0, n1);
    tests++; if (n0 + n1 !== 0) begin fails++; $display("FAIL mt_busy got %0d exp 0", n0 + n1); end
    tests++; if ({hi0, lo0} !== 64'hAAAA0000_00005555) begin fails++; $display("FAIL mthi_mtlo got %h exp AAAA000000005555", {hi0, lo0}); end
  endtask
  task automatic test_issue_while_busy;
    int n;
    start0 = 1'b1; op0 = 3'b000; a0 = 32'd2; b0 = 32'd3;
    @(negedge clk);
    start0 = 1'b0;
    n = 0;
    while (busy0 && n < 40) begin
      n++;
      start0 = (n == 2);
      a0 = 32'd100;
      b0 = 32'd100;
      @(negedge clk);
    end
    start0 = 1'b0;
    tests++; if (n !== 5) begin fails++; $display("FAIL ignore_busy got %0d exp 5", n); end
    tests++; if ({hi0, lo0} !== 64'd6) begin fails++; $display("FAIL ignore_result got %h exp 6", {hi0, lo0}); end
    do_op(0, 3'b100, 32'hAAAA0000, 32'h0, n);
  endtask
  task automatic test_reset_mid_op;
    int n;
    start0 = 1'b1; op0 = 3'b010; a0 = 32'd100; b0 = 32'd7;
    @(negedge clk);
    start0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #2;
    tests++; if (busy0 !== 1'b1) begin fails++; $display("FAIL pre_reset_busy got %b exp 1", busy0); end
    reset = 1'b1;
    #1;
    tests++; if (busy0 !== 1'b0) begin fails++; $display("FAIL async_reset_busy got %b exp 0", busy0); end
    tests++; if ({hi0, lo0} !== 64'h0) begin fails++; $display("FAIL async_reset_hilo got %h exp 0", {hi0, lo0}); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    do_op(0, 3'b000, 32'd3, 32'd4, n);
    tests++; if (n !== 5) begin fails++; $display("FAIL post_reset_busy got %0d exp 5", n); end
    tests++; if ({hi0, lo0} !== 64'd12) begin fails++; $display("FAIL post_reset_mult got %h exp 12", {hi0, lo0}); end
  endtask
  task automatic test_madd;
    int n;
    do_op(0, 3'b100, 32'h0, 32'h0, n);
    do_op(0, 3'b101, 32'hFFFFFFFF, 32'h0, n);
    do_op(0, 3'b110, 32'h1, 32'h1, n);
`ifdef MD_MADD_EN
    tests++; if (n !== 5) begin fails++; $display("FAIL madd_busy got %0d exp 5", n); end
    tests++; if ({hi0, lo0} !== 64'h00000001_00000000) begin fails++; $display("FAIL madd got %h exp 0000000100000000", {hi0, lo0}); end
`else
    tests++; if (n !== 0) begin fails++; $display("FAIL madd_off_busy got %0d exp 0", n); end
    tests++; if ({hi0, lo0} !== 64'h00000000_FFFFFFFF) begin fails++; $display("FAIL madd_off got %h exp 00000000FFFFFFFF", {hi0, lo0}); end
`endif
  endtask
  task automatic test_latency;
    int n;
    do_op(1, 3'b000, 32'd5, 32'd6, n);
    tests++; if (n !== 1) begin fails++; $display("FAIL lat_mult_busy got %0d exp 1", n); end
    tests++; if ({hi1, lo1} !== 64'd30) begin fails++; $display("FAIL lat_mult got %h exp 30", {hi1, lo1}); end
    do_op(1, 3'b010, 32'd100, 32'd7, n);
    tests++; if (n !== 15) begin fails++; $display("FAIL lat_div_busy got %0d exp 15", n); end
    tests++; if ({hi1, lo1} !== 64'h00000002_0000000E) begin fails++; $display("FAIL lat_div got %h exp 000000020000000E", {hi1, lo1}); end
  endtask
  task automatic test_back_to_back;
    int n;
    do_op(1, 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, n);
    tests++; if ({hi1, lo1} !== 64'hFFFFFFFE_00000001) begin fails++; $display("FAIL b2b_first got %h exp FFFFFFFE00000001", {hi1, lo1}); end
    do_op(1, 3'b011, 32'd9, 32'd4, n);
    tests++; if (n !== 15) begin fails++; $display("FAIL b2b_busy got %0d exp 15", n); end
    tests++; if ({hi1, lo1} !== 64'h00000001_00000002) begin fails++; $display("FAIL b2b_second got %h exp 0000000100000002", {hi1, lo1}); end
  endtask
  initial begin
    test_reset;
    test_mult;
    test_div;
    test_div_boundary;
    test_reserved;
    test_mthi_mtlo;
    test_issue_while_busy;
    test_reset_mid_op;
    test_madd;
    test_latency;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multi-cycle multiply/divide unit with HI/LO registers for the next pipeline generation.
- Sits in the EX stage beside the ALU.
- Exposes `busy` so the hazard logic can stall mult/div/mfhi/mflo/mthi/mtlo in ID. This replaces the pipeline's always-enabled, stall-free model.
- Operand width and per-operation latency are parametrised.

Parameters:
- WIDTH, 32: operand width; HI and LO are each WIDTH bits.
- MUL_CYCLES, 5: busy cycles for mult/multu/madd; legal range 1..15.
- DIV_CYCLES, 10: busy cycles for div/divu; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  issue strobe from EX; sampled on the rising edge.
- op  input  3  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, 110 madd; 111 reserved.
- a  input  WIDTH  rs operand (forwarded value).
- b  input  WIDTH  rt operand (forwarded value).
- busy  output  1  operation in progress.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (async, active-high):
  - State forced to IDLE; busy=0, hi=0, lo=0.
  - This applies at any time, including mid-operation; the in-flight result is discarded.
- States:
  - IDLE: busy=0.
  - RUN: busy=1; a down-counter `cnt` of width clog2(15)+1 runs.
- Transitions:
  - IDLE, start=1, op in {mult, multu, div, divu, madd}:
    - The result is computed from a and b sampled at that edge and held in pending registers.
    - Set cnt = MUL_CYCLES or DIV_CYCLES; go to RUN.
  - RUN, cnt>1: decrement cnt.
  - RUN, cnt==1: write pending HI/LO into hi/lo and return to IDLE on the same edge.
  - Result: busy is high for exactly N cycles after the issue edge. hi/lo change on the edge where busy falls.
- mthi / mtlo:
  - Accepted only in IDLE with start=1.
  - hi<=a (mthi) or lo<=a (mtlo) on that edge. The other register is unchanged; busy stays 0.
- start while RUN:
  - Ignored entirely; the hazard unit guarantees this cannot occur.
  - Implementation includes a simulation-only $display warning, excluded from synthesis.
- op=111 with start=1: no-op; state and registers unchanged.
- Multiply:
  - mult is signed WIDTH x WIDTH -> 2*WIDTH; multu is unsigned.
  - {hi,lo} = full product.
- Divide:
  - lo = quotient truncated toward zero; hi = remainder, which takes the sign of the dividend (a).
  - div is signed; divu is unsigned.
  - b==0: operation still takes DIV_CYCLES busy cycles; hi and lo are left unchanged at completion.
  - Signed overflow (a = most-negative, b = -1): lo = most-negative, hi = 0.
- hi/lo are register outputs with no combinational path from a, b, or op.

Optional Feature:
- Macro: MD_MADD_EN.
- Defined:
  - op=110 (madd) computes {hi,lo} <= {hi,lo} + signed(a)*signed(b), modulo 2^(2*WIDTH).
  - The accumulate uses hi/lo as they stand at completion time; they cannot change during RUN.
  - Latency is MUL_CYCLES.
- Not defined:
  - op=110 is treated as reserved (no-op, like 111).
  - No accumulator adder is instantiated.

Test Plan:
1. mult, a=0xFFFFFFFF, b=0x00000002 -> busy=1 for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE on the edge busy falls. multu with the same operands -> hi=0x00000001, lo=0xFFFFFFFE.
2. div, a=0xFFFFFFF9 (-7), b=2 -> busy 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu, a=7, b=2 -> lo=3, hi=1.
3. Boundary divides:
   - Preload hi=0x11, lo=0x22 via mthi/mtlo; divu with b=0 -> busy 10 cycles, then hi=0x11, lo=0x22.
   - div a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
4. Issue and reset timing:
   - mthi a=0xAAAA0000 then mtlo a=0x5555 on consecutive cycles -> hi=0xAAAA0000, lo=0x5555, busy never rises.
   - mult issued during RUN -> ignored; hi/lo reflect only the first operation.
   - Reset asserted on cycle 4 of a div -> busy=0, hi=lo=0 immediately (async). After release, a new mult completes normally.
5. With MD_MADD_EN: hi=0, lo=0xFFFFFFFF, madd a=1, b=1 -> after 5 cycles hi=1, lo=0. Without the macro, the same stimulus leaves hi/lo unchanged and busy=0.
6. Latency override MUL_CYCLES=1, DIV_CYCLES=15:
   - mult -> busy high exactly 1 cycle.
   - div -> busy high exactly 15 cycles.
   - Back-to-back issue on the cycle after busy falls is accepted.
